// File: rtl/program_counter_stack_if.sv
// Fetch-control bus between the decode stage and the program counter / return stack.
// Decode issues one command per cycle and observes the PC and stack status.
interface program_counter_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  // Commands from decode
  logic             en;
  logic             clear;
  logic             load;
  logic             branch;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] offset;

  // Registered PC and stack status
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output en, clear, load, branch, call, ret, addr, offset,
    input  out, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  en, clear, load, branch, call, ret, addr, offset,
    output out, depth, full, empty, overflow, underflow
  );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with configurable step/reset vector, PC-relative branch,
// synchronous clear, stall, and a call/return address stack with sticky
// overflow/underflow reporting. The PC output is purely registered.
module program_counter_stack #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      DEPTH      = 8,
  parameter int unsigned      STEP       = 1,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input logic                   clk,
  input logic                   reset,
  program_counter_stack_if.slave bus
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    CMD_CLEAR,
    CMD_HOLD,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET,
    CMD_BRANCH,
    CMD_INC
  } cmd_e;

  cmd_e             cmd;

  logic [WIDTH-1:0] pc_q,    pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q,   ovf_d;
  logic             unf_q,   unf_d;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             push;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  logic [WIDTH-1:0] pc_inc;
  logic             full;
  logic             empty;

  assign pc_inc = pc_q + WIDTH'(STEP);
  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);
  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - DW'(1));

  // Priority decode: exactly one command wins, the rest are ignored outright
  always_comb begin
    cmd = CMD_INC;
    if (bus.clear)       cmd = CMD_CLEAR;
    else if (!bus.en)    cmd = CMD_HOLD;
    else if (bus.load)   cmd = CMD_LOAD;
    else if (bus.call)   cmd = CMD_CALL;
    else if (bus.ret)    cmd = CMD_RET;
    else if (bus.branch) cmd = CMD_BRANCH;
  end

  // Next PC, stack occupancy and sticky flags for the selected command
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (cmd)
      CMD_CLEAR: begin
        pc_d    = RESET_ADDR;
        depth_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      CMD_HOLD: begin
      end
      CMD_LOAD: begin
        pc_d = bus.addr;
      end
      CMD_CALL: begin
        // A call while full still jumps; only the return address is lost
        pc_d = bus.addr;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + DW'(1);
        end
      end
      CMD_RET: begin
        // A return from an empty stack falls through to the next instruction
        if (empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d    = stack_q[rd_idx];
          depth_d = depth_q - DW'(1);
        end
      end
      CMD_BRANCH: begin
        pc_d = pc_q + bus.offset;
      end
      CMD_INC: begin
        pc_d = pc_inc;
      end
      default: begin
      end
    endcase
  end

  // PC, occupancy and flags; async reset returns to the reset vector at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are meaningless above depth, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign bus.out       = pc_q;
  assign bus.depth     = depth_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: an 8-deep instance for sequencing,
// branching, clear and async reset, and a 2-deep instance for overflow/underflow.
module tb_program_counter_stack;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   errors;
  int   checks;

  program_counter_stack_if #(.WIDTH(16), .DEPTH(8)) bus_a ();
  program_counter_stack_if #(.WIDTH(16), .DEPTH(2)) bus_b ();

  program_counter_stack #(
    .WIDTH(16), .DEPTH(8), .STEP(1), .RESET_ADDR(16'h0000)
  ) dut_a (
    .clk(clk), .reset(rst_a_n), .bus(bus_a)
  );

  program_counter_stack #(
    .WIDTH(16), .DEPTH(2), .STEP(1), .RESET_ADDR(16'h0000)
  ) dut_b (
    .clk(clk), .reset(rst_b_n), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.en = 1'b1; bus_a.clear = 1'b0; bus_a.load = 1'b0;
    bus_a.branch = 1'b0; bus_a.call = 1'b0; bus_a.ret = 1'b0;
    bus_a.addr = '0; bus_a.offset = '0;
  endtask

  task automatic idle_b();
    bus_b.en = 1'b0; bus_b.clear = 1'b0; bus_b.load = 1'b0;
    bus_b.branch = 1'b0; bus_b.call = 1'b0; bus_b.ret = 1'b0;
    bus_b.addr = '0; bus_b.offset = '0;
  endtask

  task automatic load_a(input logic [15:0] a);
    idle_a(); bus_a.load = 1'b1; bus_a.addr = a; tick(); idle_a();
  endtask

  task automatic call_a(input logic [15:0] a);
    idle_a(); bus_a.call = 1'b1; bus_a.addr = a; tick(); idle_a();
  endtask

  task automatic ret_a();
    idle_a(); bus_a.ret = 1'b1; tick(); idle_a();
  endtask

  task automatic branch_a(input logic [15:0] o);
    idle_a(); bus_a.branch = 1'b1; bus_a.offset = o; tick(); idle_a();
  endtask

  task automatic call_b(input logic [15:0] a);
    idle_b(); bus_b.en = 1'b1; bus_b.call = 1'b1; bus_b.addr = a; tick(); idle_b();
  endtask

  task automatic ret_b();
    idle_b(); bus_b.en = 1'b1; bus_b.ret = 1'b1; tick(); idle_b();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_a();
    idle_b();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_out", bus_a.out, 16'h0000);
    check("rst_depth", bus_a.depth, 0);
    check("rst_empty", bus_a.empty, 1);
    check("rst_full", bus_a.full, 0);
    check("rst_ovf", bus_a.overflow, 0);
    check("rst_unf", bus_a.underflow, 0);

    // Sequential advance after release
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    check("inc_0", bus_a.out, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("inc_n", bus_a.out, 32'(i));
    end
    check("inc_depth", bus_a.depth, 0);
    check("inc_flags", {bus_a.overflow, bus_a.underflow}, 0);

    // Wrap at top of address space
    load_a(16'hFFFF);
    check("load_ffff", bus_a.out, 16'hFFFF);
    tick();
    check("wrap", bus_a.out, 16'h0000);

    // Priority: load beats call and branch; stall beats load
    load_a(16'h0010);
    check("pri_pre", bus_a.out, 16'h0010);
    bus_a.load = 1'b1; bus_a.addr = 16'h0100;
    bus_a.call = 1'b1; bus_a.branch = 1'b1; bus_a.offset = 16'h0004;
    tick();
    idle_a();
    check("pri_out", bus_a.out, 16'h0100);
    check("pri_depth", bus_a.depth, 0);
    bus_a.en = 1'b0; bus_a.load = 1'b1; bus_a.addr = 16'h0AAA;
    tick();
    idle_a();
    check("stall_out", bus_a.out, 16'h0100);

    // Nested call/return
    load_a(16'h0020);
    call_a(16'h0200);
    check("call1_out", bus_a.out, 16'h0200);
    check("call1_depth", bus_a.depth, 1);
    call_a(16'h0300);
    check("call2_out", bus_a.out, 16'h0300);
    check("call2_depth", bus_a.depth, 2);
    ret_a();
    check("ret1_out", bus_a.out, 16'h0201);
    check("ret1_depth", bus_a.depth, 1);
    ret_a();
    check("ret2_out", bus_a.out, 16'h0021);
    check("ret2_depth", bus_a.depth, 0);
    check("ret2_empty", bus_a.empty, 1);
    ret_a();
    check("unf_out", bus_a.out, 16'h0022);
    check("unf_flag", bus_a.underflow, 1);

    // Branch sign handling and zero offset
    load_a(16'h0050);
    branch_a(16'hFFF0);
    check("br_neg", bus_a.out, 16'h0040);
    branch_a(16'h0008);
    check("br_pos", bus_a.out, 16'h0048);
    branch_a(16'h0000);
    check("br_zero", bus_a.out, 16'h0048);

    // Clear mid-stack overrides a stall and a pending call
    call_a(16'h1000);
    call_a(16'h2000);
    call_a(16'h3000);
    check("pre_clr_depth", bus_a.depth, 3);
    check("unf_sticky", bus_a.underflow, 1);
    bus_a.clear = 1'b1; bus_a.en = 1'b0; bus_a.call = 1'b1; bus_a.addr = 16'h4444;
    tick();
    idle_a();
    check("clr_out", bus_a.out, 16'h0000);
    check("clr_depth", bus_a.depth, 0);
    check("clr_unf", bus_a.underflow, 0);

    // Asynchronous reset between edges during a stall
    call_a(16'h0100);
    call_a(16'h0200);
    call_a(16'h1234);
    check("pre_arst_out", bus_a.out, 16'h1234);
    check("pre_arst_depth", bus_a.depth, 3);
    bus_a.en = 1'b0;
    #2;
    rst_a_n = 1'b0;
    #1;
    check("arst_out", bus_a.out, 16'h0000);
    check("arst_depth", bus_a.depth, 0);
    tick();
    rst_a_n = 1'b1;
    idle_a();

    // Overflow/underflow on the 2-deep stack
    check("b_start", bus_b.out, 16'h0000);
    call_b(16'h0A00);
    call_b(16'h0B00);
    check("b_full", bus_b.full, 1);
    check("b_ovf_pre", bus_b.overflow, 0);
    call_b(16'h0C00);
    check("b_ovf_out", bus_b.out, 16'h0C00);
    check("b_ovf_depth", bus_b.depth, 2);
    check("b_ovf_flag", bus_b.overflow, 1);
    ret_b();
    check("b_ret1", bus_b.out, 16'h0A01);
    ret_b();
    check("b_ret2", bus_b.out, 16'h0001);
    check("b_empty", bus_b.empty, 1);
    check("b_unf_pre", bus_b.underflow, 0);
    ret_b();
    check("b_unf_out", bus_b.out, 16'h0002);
    check("b_unf_flag", bus_b.underflow, 1);
    check("b_ovf_sticky", bus_b.overflow, 1);
    idle_b(); bus_b.clear = 1'b1;
    tick();
    idle_b();
    check("b_clr_flags", {bus_b.overflow, bus_b.underflow}, 0);
    check("b_clr_out", bus_b.out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
